// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin arbiter giving the instruction fetch path (port 0)
// and the debug/loader read path (port 1) shared access to program memory.
// One transaction at a time: IDLE picks a winner, BUSY waits for the memory
// acknowledge (or aborts after TIMEOUT cycles), DONE shows the result for one cycle.
module imem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic [31:0] i_addr0,
    input  logic [31:0] i_addr1,
    output logic [31:0] or_rdata0,
    output logic [31:0] or_rdata1,
    output logic        or_ack0,
    output logic        or_ack1,
    output logic        or_err0,
    output logic        or_err1,
    output logic        or_mem_req,
    output logic [31:0] or_mem_addr,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack
);

    // Counter only has to reach TIMEOUT-1; it is cleared on every BUSY entry.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             grant;       // port owning the current transaction
    logic             last_grant;  // port that won the previous arbitration
    logic [CNT_W-1:0] cnt;         // BUSY cycles elapsed without a memory ack
    logic             any_req;
    logic             winner;
    logic [31:0]      win_addr;

    // Round-robin pick: a lone requester wins; under contention the port
    // that did not win last time goes next, giving strict alternation.
    always_comb begin
        any_req  = i_req0 | i_req1;
        winner   = 1'b0;
        if (i_req0 && i_req1) begin
            winner = ~last_grant;
        end else if (i_req1) begin
            winner = 1'b1;
        end
        win_addr = winner ? i_addr1 : i_addr0;
    end

    // Transaction FSM with all outputs registered; the non-granted port's
    // data/ack/err registers are never touched by a transaction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            cnt         <= '0;
            or_mem_req  <= 1'b0;
            or_mem_addr <= '0;
            or_rdata0   <= '0;
            or_rdata1   <= '0;
            or_ack0     <= 1'b0;
            or_ack1     <= 1'b0;
            or_err0     <= 1'b0;
            or_err1     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant       <= winner;
                        last_grant  <= winner;
                        or_mem_addr <= win_addr;
                        or_mem_req  <= 1'b1;
                        cnt         <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack arriving on the final counted cycle still wins.
                    if (i_mem_ack) begin
                        if (grant) begin
                            or_rdata1 <= i_mem_rdata;
                            or_ack1   <= 1'b1;
                        end else begin
                            or_rdata0 <= i_mem_rdata;
                            or_ack0   <= 1'b1;
                        end
                        or_mem_req <= 1'b0;
                        state      <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        if (grant) begin
                            or_rdata1 <= '0;
                            or_err1   <= 1'b1;
                        end else begin
                            or_rdata0 <= '0;
                            or_err0   <= 1'b1;
                        end
                        or_mem_req <= 1'b0;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DONE: begin
                    // Result pulse lasts exactly one cycle; no arbitration here.
                    or_ack0 <= 1'b0;
                    or_ack1 <= 1'b0;
                    or_err0 <= 1'b0;
                    or_err1 <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter sharing the single program memory between the instruction fetch path (port 0) and the debug/loader read path (port 1). It accepts request/ack transactions from both requesters, grants round-robin, and drives the memory's request/address lines. It returns data and a one-cycle acknowledge to the winner. A transaction that the memory does not acknowledge within a bounded number of cycles is aborted with an error pulse. It sits between the core's fetch stage and `program_memory`; it is the only master of that memory.

## Interface
- `TIMEOUT`, default 15: BUSY cycles without `i_mem_ack` before the transaction is aborted; must be ≥1.
- `i_clk`  in  1  system clock; all state changes on the rising edge.
- `i_rst`  in  1  reset, synchronous and active-high.
- `i_req0` / `i_req1`  in  1  request from port 0 (fetch) / port 1 (debug).
- `i_addr0` / `i_addr1`  in  32  request address; held stable while the request is high.
- `or_rdata0` / `or_rdata1`  out  32  returned instruction word, registered.
- `or_ack0` / `or_ack1`  out  1  one-cycle completion pulse.
- `or_err0` / `or_err1`  out  1  one-cycle timeout pulse.
- `or_mem_req`  out  1  request to program memory.
- `or_mem_addr`  out  32  address to program memory.
- `i_mem_rdata`  in  32  memory instruction data.
- `i_mem_ack`  in  1  memory acknowledge; may be combinational from `or_mem_req`.

## Operation
- Reset values: all outputs 0; state IDLE; `last_grant` 1 (port 0 wins the first tie); timeout counter 0; `grant` 0.
- States:
  - IDLE: no memory request. If any `i_reqN` is high, select the winner, latch its address into `or_mem_addr`, set `or_mem_req`=1, clear the counter, set `last_grant`=winner, and go to BUSY.
  - BUSY: `or_mem_req`=1.
    - If `i_mem_ack`: capture `i_mem_rdata` into `or_rdata[grant]`, set `or_ack[grant]`=1, `or_mem_req`=0, go to DONE.
    - Else if counter == TIMEOUT-1: set `or_rdata[grant]`=0, `or_err[grant]`=1, `or_mem_req`=0, go to DONE.
    - Else: counter += 1.
  - DONE: ack/err is visible for exactly this cycle. No arbitration. Clear ack/err and go to IDLE.
- Arbitration:
  - Only one port requesting: that port wins.
  - Both requesting: the port ≠ `last_grant` wins (strict alternation under contention).
- Requester rule: keep `i_reqN` high with a stable address until ack or err is seen. Drop the request no later than the edge ending the DONE cycle. A request still high in IDLE is treated as a new transaction.
- Request withdrawn during BUSY: ignored. The transaction still completes and the ack/err pulse is still issued.
- `i_mem_ack` on the same cycle the counter reaches TIMEOUT-1: ack wins and no error is raised.
- `i_mem_ack` while not in BUSY: ignored.
- `or_rdataN` holds its last value between transactions. The non-granted port's data, ack and err never change.
- `or_mem_addr` holds the last issued address after completion.
- At most one of `or_ack0`, `or_ack1`, `or_err0`, `or_err1` is high in any cycle.
- Counter width is $clog2(TIMEOUT+1), unsigned; it never wraps because it is cleared on BUSY entry.

## Timing
- Edge E0: request sampled in IDLE. From E0 to E1, `or_mem_req`=1 and the address is valid.
- Zero-wait memory (combinational ack): ack seen at E1; `or_ackN` and `or_rdataN` valid from E1 to E2; IDLE from E2.
- Latency, request sample to ack visible: 1 + W cycles, where W = memory wait cycles.
- Throughput: one transaction per 3 cycles with zero-wait memory.
- Timeout: err is visible TIMEOUT cycles after BUSY entry, for one cycle.
- Reset mid-operation: at the reset edge all outputs return to reset values, including `or_mem_req`=0 and no ack/err. Requests pending during reset are sampled in the first IDLE cycle after `i_rst` falls.

## Test plan
- Single fetch: `i_req0`=1, `i_addr0`=0x10, memory returns 0x00500093 with combinational ack.
  - `or_mem_addr`=0x10 for one cycle.
  - `or_ack0` pulses at the next edge with `or_rdata0`=0x00500093.
  - `or_ack1` and `or_err*` stay 0.
- Contention from reset: both requests high (addr0=0x4, addr1=0x8), held through three transactions.
  - Grants go port 0, port 1, port 0.
  - `or_mem_addr` sequence is 0x4, 0x8, 0x4; acks alternate.
- Wait states: memory acks 3 cycles after `or_mem_req` rises, data 0xDEADBEEF.
  - `or_ack0` appears 4 cycles after the request sample, `or_rdata0`=0xDEADBEEF, no err.
- Timeout: TIMEOUT=15, memory never acks.
  - `or_err1` pulses once, exactly 15 cycles after BUSY entry, with `or_rdata1`=0.
  - FSM returns to IDLE.
  - Repeat with ack on the 15th cycle: `or_ack1` pulses, no err.
- Withdrawn request: `i_req0` drops one cycle into a 2-wait transaction.
  - `or_ack0` still pulses once; no second transaction is issued.
- Reset mid-BUSY: assert `i_rst` during a wait state.
  - All outputs are 0 at the next edge and no ack is issued.
  - After release with `i_req1`=1, port 1 transacts normally.
